// File: rtl/parity_pkg.sv
// Shared FSM state encoding and requester-id constants for the parity arbiter.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic ReqId0 = 1'b0;
  localparam logic ReqId1 = 1'b1;

  function automatic logic other_id(logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the pointed requester.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/parity_arbiter.sv
// Arbitrates two requesters onto one even-parity checker and keeps a
// saturating error count per requester.
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_parity,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_parity,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_error,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  logic             ptr_q;
  logic [WIDTH-1:0] data_q;
  logic             parity_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic             rsp_error_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic [1:0]       gnt;
  logic             in_idle;
  logic             accept;
  logic             acc_id;
  logic [WIDTH-1:0] acc_data;
  logic             acc_parity;
  logic             chk_err;

  rr_arb2 u_rr_arb2 (
    .valid_i ({req1_valid, req0_valid}),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt)
  );

  assign in_idle    = (state_q == StIdle);
  assign req0_ready = in_idle & gnt[0];
  assign req1_ready = in_idle & gnt[1];
  assign accept     = req0_ready | req1_ready;
  assign acc_id     = gnt[1] ? ReqId1 : ReqId0;
  assign acc_data   = gnt[1] ? req1_data : req0_data;
  assign acc_parity = gnt[1] ? req1_parity : req0_parity;
  assign chk_err    = (^data_q) ^ parity_q;

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if ((state_q == StCheck) && chk_err) begin
      if (id_q == ReqId0) begin
        if (cnt0_q != CntMax) cnt0_d = cnt0_q + CNT_W'(1);
      end else begin
        if (cnt1_q != CntMax) cnt1_d = cnt1_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= ReqId0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      id_q        <= ReqId0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_q   <= acc_data;
            parity_q <= acc_parity;
            id_q     <= acc_id;
            busy_q   <= 1'b1;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          rsp_error_q <= chk_err;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= other_id(id_q);
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_error = rsp_error_q;
  assign err_cnt0  = cnt0_q;
  assign err_cnt1  = cnt1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// Self-checking bench for parity_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model.
module tb_parity_arbiter;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int          CntMax = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_parity, req1_parity;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_error;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt0, err_cnt1;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parity_arbiter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_parity (req0_parity),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_parity (req1_parity),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_error   (rsp_error),
    .clr_cnt     (clr_cnt),
    .err_cnt0    (err_cnt0),
    .err_cnt1    (err_cnt1),
    .busy        (busy)
  );

  // Expected mismatch: total number of ones (data plus parity bit) is odd.
  function automatic logic exp_err(logic [WIDTH-1:0] d, logic p);
    return ((($countones(d) + int'(p)) % 2) == 1);
  endfunction

  function automatic logic bad_par(logic [WIDTH-1:0] d);
    return (($countones(d) % 2) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_parity = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_parity = 1'b0;
    rsp_ready  = 1'b0; clr_cnt   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offers one word, waits (bounded) for acceptance and then for rsp_valid.
  // lat is the number of edges from the accepting edge to rsp_valid, -1 if none.
  task automatic offer(input logic id, input logic [WIDTH-1:0] d, input logic p,
                       output bit acc, output int lat);
    acc = 1'b0;
    lat = -1;
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_parity = p;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_parity = p;
    end
    #1;
    for (int i = 0; i < 10 && !acc; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) acc = 1'b1;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (acc) begin
      for (int i = 0; i < 10 && lat < 0; i++) begin
        if (rsp_valid === 1'b1) lat = i + 1;
        else tick();
      end
    end
  endtask

  task automatic test_reset();
    bit acc;
    int lat;
    do_reset();
    n_cmp++;
    if ({busy, rsp_valid, rsp_id, rsp_error, req0_ready, req1_ready, err_cnt0, err_cnt1}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b rv=%b id=%b err=%b rdy=%b%b c0=%0d c1=%0d, want all 0",
               busy, rsp_valid, rsp_id, rsp_error, req1_ready, req0_ready, err_cnt0, err_cnt1);
    end
    // Build up state, then reset on top of clear and live handshakes.
    rsp_ready = 1'b0;
    offer(1'b1, 8'h01, 1'b0, acc, lat);
    req0_valid = 1'b1; req1_valid = 1'b1; clr_cnt = 1'b1; rsp_ready = 1'b1; rst = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rsp_valid, rsp_id, rsp_error, err_cnt0, err_cnt1} !== '0) begin
      n_bad++;
      $display("FAIL reset_over_resp: got busy=%b rv=%b id=%b err=%b c0=%0d c1=%0d, want all 0",
               busy, rsp_valid, rsp_id, rsp_error, err_cnt0, err_cnt1);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_pointer: got rdy1,rdy0=%b%b want 01", req1_ready, req0_ready);
    end
    idle_inputs();
  endtask

  task automatic test_good_word();
    bit acc;
    int lat;
    do_reset();
    rsp_ready = 1'b1;
    offer(1'b0, 8'hA5, 1'b0, acc, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL good_latency: got %0d want 2 (accepted=%0d)", lat, acc);
    end
    n_cmp++;
    if ({rsp_id, rsp_error, err_cnt0} !== {1'b0, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL good_result: got id=%b err=%b c0=%0d want id=0 err=0 c0=0",
               rsp_id, rsp_error, err_cnt0);
    end
    tick();
    n_cmp++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL good_release: got busy=%b rv=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_error_word();
    bit acc;
    int lat;
    rsp_ready = 1'b1;
    offer(1'b1, 8'h01, 1'b0, acc, lat);
    n_cmp++;
    if ({lat == 2, rsp_id, rsp_error, err_cnt1, err_cnt0} !== {1'b1, 1'b1, 1'b1, 2'd1, 2'd0})
    begin
      n_bad++;
      $display("FAIL error_result: got lat=%0d id=%b err=%b c1=%0d c0=%0d want 2 1 1 1 0",
               lat, rsp_id, rsp_error, err_cnt1, err_cnt0);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] dat[2];
    logic             par[2];
    logic             exp_w = 1'b0;
    logic             q_id[$];
    logic             q_err[$];
    int               grants = 0;
    int               last_acc = 0;
    int               refresh = -1;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dat[i] = WIDTH'($urandom);
      par[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
      req0_valid = 1'b1; req0_data = dat[0]; req0_parity = par[0];
      req1_valid = 1'b1; req1_data = dat[1]; req1_parity = par[1];
      #1;
      refresh = -1;
      if (req0_ready || req1_ready) begin
        n_cmp++;
        if ({req1_ready, req0_ready} !== (exp_w ? 2'b10 : 2'b01)) begin
          n_bad++;
          $display("FAIL rr_grant%0d: got rdy1,rdy0=%b%b want winner %0d",
                   grants, req1_ready, req0_ready, exp_w);
        end
        if (grants > 0) begin
          n_cmp++;
          if (cyc - last_acc < 3) begin
            n_bad++;
            $display("FAIL rr_gap%0d: got %0d cycles want >=3", grants, cyc - last_acc);
          end
        end
        q_id.push_back(exp_w);
        q_err.push_back(exp_err(dat[exp_w], par[exp_w]));
        refresh  = int'(exp_w);
        last_acc = cyc;
        grants++;
        exp_w = ~exp_w;
      end
      if (rsp_valid === 1'b1 && q_id.size() > 0) begin
        n_cmp++;
        if ({rsp_id, rsp_error} !== {q_id[0], q_err[0]}) begin
          n_bad++;
          $display("FAIL rr_rsp: got id=%b err=%b want id=%b err=%b",
                   rsp_id, rsp_error, q_id[0], q_err[0]);
        end
        void'(q_id.pop_front());
        void'(q_err.pop_front());
      end
      tick();
      if (refresh >= 0) begin
        dat[refresh] = WIDTH'($urandom);
        par[refresh] = 1'($urandom_range(0, 1));
      end
    end
    n_cmp++;
    if (grants != 8) begin
      n_bad++;
      $display("FAIL rr_progress: got %0d grants want 8", grants);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_hold();
    bit   acc;
    int   lat;
    logic h_id, h_err;
    int   bad = 0;
    do_reset();
    rsp_ready = 1'b0;
    offer(1'b1, 8'h37, 1'b1, acc, lat);
    h_id  = exp_err(8'h37, 1'b1);
    n_cmp++;
    if ({lat == 2, rsp_id, rsp_error} !== {1'b1, 1'b1, h_id}) begin
      n_bad++;
      $display("FAIL hold_first: got lat=%0d id=%b err=%b want 2 1 %b", lat, rsp_id, rsp_error,
               h_id);
    end
    h_id  = rsp_id;
    h_err = rsp_error;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({rsp_valid, rsp_id, rsp_error, req0_ready, req1_ready, busy}
          !== {1'b1, h_id, h_err, 1'b0, 1'b0, 1'b1}) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_cmp++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL hold_release: got busy=%b rv=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_saturate();
    bit               acc;
    int               lat;
    logic [WIDTH-1:0] d;
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      d = WIDTH'($urandom);
      offer(1'b0, d, bad_par(d), acc, lat);
      n_cmp++;
      if ({rsp_error, int'(err_cnt0)} !== {1'b1, (k < CntMax) ? k : CntMax}) begin
        n_bad++;
        $display("FAIL sat_word%0d: got err=%b c0=%0d want err=1 c0=%0d", k, rsp_error,
                 err_cnt0, (k < CntMax) ? k : CntMax);
      end
      tick();
    end
    d = WIDTH'($urandom);
    req0_valid = 1'b1; req0_data = d; req0_parity = bad_par(d);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_sixth_ready: got %b want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_error, err_cnt0} !== {1'b1, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL sat_clear_wins: got rv=%b err=%b c0=%0d want 1 1 0",
               rsp_valid, rsp_error, err_cnt0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h01; req1_parity = 1'b0;
    tick();
    req1_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_in_check: got busy=%b want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({busy, rsp_valid, err_cnt0, err_cnt1} !== '0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL abort_lost: got %0d cycles with activity want 0", bad);
    end
  endtask

  task automatic test_random();
    logic             out_m = 1'b0;
    int               age_m = 0;
    logic             id_m = 1'b0;
    logic             err_m = 1'b0;
    logic             ptr_m = 1'b0;
    int               c0 = 0;
    int               c1 = 0;
    logic             v0, v1, clr, er0, er1, rv;
    logic [WIDTH-1:0] d0, d1;
    logic             p0, p1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = WIDTH'($urandom);
      d1 = WIDTH'($urandom);
      p0 = 1'($urandom_range(0, 1));
      p1 = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      req0_valid = v0; req0_data = d0; req0_parity = p0;
      req1_valid = v1; req1_data = d1; req1_parity = p1;
      clr_cnt = clr;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      er0 = !out_m && v0 && (!v1 || !ptr_m);
      er1 = !out_m && v1 && (!v0 || ptr_m);
      rv  = out_m && (age_m >= 2);
      n_cmp++;
      if ({req0_ready, req1_ready, busy, rsp_valid, int'(err_cnt0), int'(err_cnt1)}
          !== {er0, er1, out_m, rv, c0, c1}) begin
        n_bad++;
        $display("FAIL rand_c%0d: got rdy=%b%b busy=%b rv=%b c0=%0d c1=%0d want %b%b %b %b %0d %0d",
                 cyc, req0_ready, req1_ready, busy, rsp_valid, err_cnt0, err_cnt1,
                 er0, er1, out_m, rv, c0, c1);
      end
      if (rv) begin
        n_cmp++;
        if ({rsp_id, rsp_error} !== {id_m, err_m}) begin
          n_bad++;
          $display("FAIL rand_rsp_c%0d: got id=%b err=%b want id=%b err=%b",
                   cyc, rsp_id, rsp_error, id_m, err_m);
        end
      end
      // Counter effect lands one edge after acceptance; a clear overrides it.
      if (clr) begin
        c0 = 0;
        c1 = 0;
      end else if (out_m && age_m == 1 && err_m) begin
        if (id_m) c1 = (c1 < CntMax) ? c1 + 1 : CntMax;
        else      c0 = (c0 < CntMax) ? c0 + 1 : CntMax;
      end
      if (rv && rsp_ready) begin
        out_m = 1'b0;
        ptr_m = ~id_m;
      end else if (out_m) begin
        age_m++;
      end else if (er0 || er1) begin
        out_m = 1'b1;
        age_m = 1;
        id_m  = er1;
        err_m = er1 ? exp_err(d1, p1) : exp_err(d0, p0);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_good_word();
    test_error_word();
    test_round_robin();
    test_hold();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parity_arbiter.md
PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data word width in bits (minimum 1).
REQ-002 SHALL have parameter CNT_W, default 8, the width of each error counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester N offers a word.
REQ-006 SHALL have ports req0_data/req1_data  input  WIDTH  word from requester N.
REQ-007 SHALL have ports req0_parity/req1_parity  input  1  received even-parity bit from requester N.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1  word from requester N accepted this cycle.
REQ-009 SHALL have port rsp_valid  output  1  check result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-011 SHALL have port rsp_id  output  1  requester that the result belongs to.
REQ-012 SHALL have port rsp_error  output  1  high when a parity mismatch was found.
REQ-013 SHALL have port clr_cnt  input  1  synchronous clear of both error counters.
REQ-014 SHALL have ports err_cnt0/err_cnt1  output  CNT_W  parity error count per requester.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK and RESP, with one shared parity-check datapath.
REQ-017 In IDLE, SHALL drive reqN_ready combinationally high only for the granted requester; at most one ready is high.
REQ-018 Grant SHALL be round-robin: if only one requester is valid, it wins; if both are valid, the requester indicated by the priority pointer wins.
REQ-019 On valid&ready in IDLE, SHALL latch data, parity and id, and SHALL go to CHECK.
REQ-020 In CHECK, SHALL register rsp_error = (XOR of all latched data bits) XOR (latched parity), SHALL update the counter, and SHALL go to RESP.
REQ-021 In RESP, SHALL hold rsp_valid=1 with stable rsp_id/rsp_error until rsp_ready=1; that cycle SHALL return to IDLE and set the pointer to the other requester.
REQ-022 Latency SHALL be: accept at cycle T gives rsp_valid at T+2 (with rsp_ready tied high, the next accept occurs at T+3 or later).
REQ-023 Outside IDLE, both readys SHALL be 0 and inputs SHALL be ignored.
REQ-024 On error, err_cntN of the served requester SHALL increment by 1 and saturate at all-ones (no wrap).
REQ-025 clr_cnt SHALL zero both counters next cycle; clear SHALL win over a simultaneous increment.
REQ-026 Deasserting valid without a handshake SHALL have no effect, and no word SHALL be accepted twice.

Reset
REQ-027 rst SHALL put the FSM in IDLE, the pointer at requester 0, counters at 0, rsp_valid/rsp_id/rsp_error at 0 and busy at 0.
REQ-028 rst asserted mid-transaction (CHECK or RESP) SHALL abort the transaction; the result SHALL be lost and no counter update SHALL occur.
REQ-029 rst SHALL take precedence over clr_cnt and all handshakes in the same cycle.

Structure
REQ-030 The FSM state encoding and the requester-id constants SHALL live in the shared package parity_pkg.
REQ-031 The 2-way round-robin grant logic SHALL be a sub-module named rr_arb2 (inputs: valids and pointer; output: one-hot grant).
REQ-032 The design SHALL be a single clock domain, with no latches and no combinational path from rsp_ready to reqN_ready.

Verification
REQ-033 Reset, then req0 with data=8'hA5, parity=0 -> rsp_valid at T+2, rsp_id=0, rsp_error=0, err_cnt0=0.
REQ-034 req1 with data=8'h01, parity=0 -> rsp_error=1, rsp_id=1, err_cnt1=1.
REQ-035 Both valid continuously, rsp_ready=1, after reset -> grants alternate 0,1,0,1 with no starvation.
REQ-036 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_error stay stable, both readys stay 0, busy=1.
REQ-037 CNT_W=2 with 5 error words from req0 -> err_cnt0 saturates at 3; clr_cnt together with a 6th error -> err_cnt0=0.
REQ-038 rst pulsed while in CHECK for an error word -> FSM returns to IDLE, err_cnt unchanged, no rsp_valid.
